// File: rtl/lcd_seq_controller.sv
// lcd_seq_controller
// Runs a panel init program from an external synchronous ROM, then streams
// a programmable number of pixel words onto an 8080-style parallel bus.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start, pix_count  begin a full sequence; pixels to stream after END
//   rom_addr/rom_data program ROM port; rom_data = {op[1:0], payload}
//   pix_data/pix_valid/pix_ready  pixel source handshake
//   busy, init_done, seq_err      sequence status
//   lcd_data, lcd_rs, lcd_wr, lcd_rd, lcd_cs, lcd_rst  panel bus
module lcd_seq_controller #(
   parameter int DATA_W      = 16,
   parameter int ROM_AW      = 8,
   parameter int CNT_W       = 20,
   parameter int CLK_PER_MS  = 100000,
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 2,
   parameter int RST_LOW_MS  = 10,
   parameter int RST_WAIT_MS = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  pix_count,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [DATA_W+1:0] rom_data,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              busy,
   output logic              init_done,
   output logic              seq_err,
   output logic [DATA_W-1:0] lcd_data,
   output logic              lcd_rs,
   output logic              lcd_wr,
   output logic              lcd_rd,
   output logic              lcd_cs,
   output logic              lcd_rst
);

   typedef enum logic [3:0] {
      IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, WR_LO, WR_HI, DELAY, PIX_WAIT, DONE
   } state_t;

   localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_MS * CLK_PER_MS - 1);
   localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_MS * CLK_PER_MS - 1);
   localparam logic [31:0] WR_LOW_LAST   = 32'(WR_LOW_CYC - 1);
   localparam logic [31:0] WR_HIGH_LAST  = 32'(WR_HIGH_CYC - 1);
   localparam logic [31:0] MS_LAST       = 32'(CLK_PER_MS - 1);

   state_t            state;
   logic [31:0]       cnt;       // phase counter; doubles as ms prescaler in DELAY
   logic [7:0]        ms_left;
   logic [CNT_W-1:0]  pix_left;
   logic              pix_mode;  // set once END is decoded: writes are pixels
   logic [1:0]        op;
   logic [DATA_W-1:0] payload;

   assign op      = rom_data[DATA_W+1:DATA_W];
   assign payload = rom_data[DATA_W-1:0];
   assign lcd_rd  = 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ms_left   <= '0;
         pix_left  <= '0;
         pix_mode  <= 1'b0;
         rom_addr  <= '0;
         pix_ready <= 1'b0;
         busy      <= 1'b0;
         init_done <= 1'b0;
         seq_err   <= 1'b0;
         lcd_data  <= '0;
         lcd_rs    <= 1'b1;
         lcd_wr    <= 1'b1;
         lcd_cs    <= 1'b1;
         lcd_rst   <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  busy      <= 1'b1;
                  init_done <= 1'b0;
                  seq_err   <= 1'b0;
                  pix_left  <= pix_count;
                  pix_mode  <= 1'b0;
                  rom_addr  <= '0;
                  lcd_rst   <= 1'b0;
                  cnt       <= '0;
                  state     <= RST_LOW;
               end
            end
            RST_LOW: begin
               if (cnt == RST_LOW_LAST) begin
                  lcd_rst <= 1'b1;
                  cnt     <= '0;
                  state   <= RST_WAIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RST_WAIT: begin
               if (cnt == RST_WAIT_LAST) begin
                  lcd_cs <= 1'b0;
                  state  <= FETCH;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            // ROM registers rom_addr at the end of FETCH; DECODE sees the entry
            FETCH: state <= DECODE;
            DECODE: begin
               case (op)
                  2'b00, 2'b01: begin
                     lcd_data <= payload;
                     lcd_rs   <= op[0];
                     lcd_wr   <= 1'b0;
                     cnt      <= '0;
                     state    <= WR_LO;
                  end
                  2'b10: begin
                     ms_left <= payload[7:0];
                     cnt     <= '0;
                     state   <= DELAY;
                  end
                  default: begin
                     pix_mode <= 1'b1;
                     if (pix_left == '0) begin
                        lcd_cs    <= 1'b1;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        state     <= DONE;
                     end else begin
                        pix_ready <= 1'b1;
                        state     <= PIX_WAIT;
                     end
                  end
               endcase
            end
            WR_LO: begin
               if (cnt == WR_LOW_LAST) begin
                  lcd_wr <= 1'b1;
                  cnt    <= '0;
                  state  <= WR_HI;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            WR_HI: begin
               if (cnt == WR_HIGH_LAST) begin
                  if (pix_mode) begin
                     if (pix_left == '0) begin
                        lcd_cs    <= 1'b1;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        state     <= DONE;
                     end else begin
                        pix_ready <= 1'b1;
                        state     <= PIX_WAIT;
                     end
                  end else if (&rom_addr) begin
                     // last ROM slot executed without END: stop, never wrap
                     seq_err <= 1'b1;
                     lcd_cs  <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end else begin
                     rom_addr <= rom_addr + ROM_AW'(1);
                     state    <= FETCH;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            DELAY: begin
               // a zero-length delay still spends this one cycle
               if (ms_left == 8'd0 || (cnt == MS_LAST && ms_left == 8'd1)) begin
                  if (&rom_addr) begin
                     seq_err <= 1'b1;
                     lcd_cs  <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end else begin
                     rom_addr <= rom_addr + ROM_AW'(1);
                     state    <= FETCH;
                  end
               end else if (cnt == MS_LAST) begin
                  cnt     <= '0;
                  ms_left <= ms_left - 8'd1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            PIX_WAIT: begin
               if (pix_valid && pix_ready) begin
                  lcd_data  <= pix_data;
                  lcd_rs    <= 1'b1;
                  lcd_wr    <= 1'b0;
                  pix_ready <= 1'b0;
                  pix_left  <= pix_left - CNT_W'(1);
                  cnt       <= '0;
                  state     <= WR_LO;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_seq_controller.sv
// tb_lcd_seq_controller
// Directed bench for lcd_seq_controller with a small synchronous ROM model
// and a passive bus monitor that logs write strobes, lcd_rst and lcd_cs edges.
module tb_lcd_seq_controller;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int CW = 20;

   localparam logic [1:0] OP_CMD  = 2'b00;
   localparam logic [1:0] OP_DATA = 2'b01;
   localparam logic [1:0] OP_DLY  = 2'b10;
   localparam logic [1:0] OP_END  = 2'b11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] pix_count = '0;
   logic [AW-1:0] rom_addr;
   logic [DW+1:0] rom_data;
   logic [DW-1:0] pix_data = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready, busy, init_done, seq_err;
   logic [DW-1:0] lcd_data;
   logic          lcd_rs, lcd_wr, lcd_rd, lcd_cs, lcd_rst;

   logic [DW+1:0] rom [0:7];
   int total = 0;
   int bad   = 0;

   lcd_seq_controller #(
      .DATA_W(DW), .ROM_AW(AW), .CNT_W(CW), .CLK_PER_MS(10),
      .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_LOW_MS(2), .RST_WAIT_MS(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pix_count(pix_count),
      .rom_addr(rom_addr), .rom_data(rom_data), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
      .init_done(init_done), .seq_err(seq_err), .lcd_data(lcd_data),
      .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_cs(lcd_cs),
      .lcd_rst(lcd_rst)
   );

   initial forever #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   // bus monitor, sampled on the falling clock edge
   int            cyc = 0;
   logic [DW-1:0] w_data[$];
   logic          w_rs[$];
   int            w_fall[$];
   int            w_low[$];
   int            rst_fall[$];
   int            rst_rise[$];
   int            cs_fall[$];
   logic [AW-1:0] cs_addr[$];
   int            unstable = 0;

   initial begin : monitor
      logic pw, pr, pc, frs;
      int fc, lc;
      logic [DW-1:0] fd;
      pw = 1'b1; pr = 1'b1; pc = 1'b1; frs = 1'b1; fc = 0; lc = 0; fd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (lcd_wr === 1'b0 && pw === 1'b1) begin
            fc = cyc; fd = lcd_data; frs = lcd_rs; lc = 0;
         end
         if (lcd_wr === 1'b0) begin
            lc++;
            if (lcd_data !== fd || lcd_rs !== frs) unstable++;
         end
         if (lcd_wr === 1'b1 && pw === 1'b0) begin
            w_data.push_back(fd); w_rs.push_back(frs);
            w_fall.push_back(fc); w_low.push_back(lc);
         end
         if (lcd_rst === 1'b0 && pr === 1'b1) rst_fall.push_back(cyc);
         if (lcd_rst === 1'b1 && pr === 1'b0) rst_rise.push_back(cyc);
         if (lcd_cs === 1'b0 && pc === 1'b1) begin
            cs_fall.push_back(cyc); cs_addr.push_back(rom_addr);
         end
         pw = lcd_wr; pr = lcd_rst; pc = lcd_cs;
      end
   end

   function automatic logic [DW+1:0] ent(input logic [1:0] op, input logic [DW-1:0] pl);
      return {op, pl};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [CW-1:0] n);
      @(posedge clk);
      #1;
      start = 1'b1;
      pix_count = n;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000; i++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic stream(input int n, input logic [DW-1:0] d0, input bit toggle, output int sent);
      logic [5:0] pat;
      logic hs;
      pat = 6'b101101;
      sent = 0;
      for (int k = 0; k < 600 && sent < n; k++) begin
         pix_valid = toggle ? pat[5 - (k % 6)] : 1'b1;
         pix_data = d0 + DW'(sent);
         hs = pix_valid & pix_ready;
         @(posedge clk);
         #1;
         if (hs) sent++;
      end
      pix_valid = 1'b0;
   endtask

   initial begin
      int wb, rb, cb, sent;
      for (int i = 0; i < 8; i++) rom[i] = ent(OP_END, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 32'({lcd_cs, lcd_wr, lcd_rd, lcd_rst, lcd_rs,
                              pix_ready, busy, init_done, seq_err}), 32'h1F0);
      check("reset_data", 32'(lcd_data), 32'h0);
      check("reset_addr", 32'(rom_addr), 32'h0);
      rst = 1'b0;

      // reset pulse timing + CMD/DATA program
      rom[0] = ent(OP_CMD, 16'h0083);
      rom[1] = ent(OP_DATA, 16'h0002);
      rom[2] = ent(OP_END, 16'h0000);
      wb = w_data.size(); rb = rst_fall.size(); cb = cs_fall.size();
      pulse_start(0);
      check("start_busy", 32'(busy), 32'd1);
      wait_done("t2_done");
      check("t1_rst_edges", 32'(rst_fall.size() - rb), 32'd1);
      check("t1_rst_low", 32'(rst_rise[rb] - rst_fall[rb]), 32'd20);
      check("t1_rst_wait", 32'(cs_fall[cb] - rst_rise[rb]), 32'd30);
      check("t1_first_addr", 32'(cs_addr[cb]), 32'd0);
      check("t2_nwr", 32'(w_data.size() - wb), 32'd2);
      check("t2_d0", 32'(w_data[wb]), 32'h0083);
      check("t2_rs0", 32'(w_rs[wb]), 32'd0);
      check("t2_low0", 32'(w_low[wb]), 32'd2);
      check("t2_d1", 32'(w_data[wb+1]), 32'h0002);
      check("t2_rs1", 32'(w_rs[wb+1]), 32'd1);
      check("t2_low1", 32'(w_low[wb+1]), 32'd2);
      check("t2_period", 32'(w_fall[wb+1] - w_fall[wb]), 32'd6);
      check("t2_status", 32'({init_done, seq_err, lcd_cs, lcd_rd, pix_ready}), 32'b10110);

      // DELAY 5 ms
      rom[0] = ent(OP_CMD, 16'h0022);
      rom[1] = ent(OP_DLY, 16'h0005);
      rom[2] = ent(OP_DATA, 16'h00AA);
      rom[3] = ent(OP_END, 16'h0000);
      wb = w_data.size();
      pulse_start(0);
      wait_done("t3_done");
      check("t3_nwr", 32'(w_data.size() - wb), 32'd2);
      check("t3_gap", 32'(w_fall[wb+1] - w_fall[wb]), 32'd58);
      check("t3_d1", 32'(w_data[wb+1]), 32'h00AA);

      // DELAY 0 ms
      rom[1] = ent(OP_DLY, 16'h0000);
      wb = w_data.size();
      pulse_start(0);
      wait_done("t3z_done");
      check("t3z_gap", 32'(w_fall[wb+1] - w_fall[wb]), 32'd9);

      // pixel stream with a stalling source
      rom[0] = ent(OP_END, 16'h0000);
      wb = w_data.size();
      pulse_start(4);
      stream(4, 16'hAAAA, 1'b1, sent);
      check("t4_sent", 32'(sent), 32'd4);
      wait_done("t4_done");
      check("t4_nwr", 32'(w_data.size() - wb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t4_pix", 32'({w_rs[wb+i], w_data[wb+i]}), 32'h1AAAA + 32'(i));
      end
      check("t4_status", 32'({init_done, seq_err, lcd_cs, pix_ready}), 32'b1010);

      // program without END runs off the ROM
      for (int i = 0; i < 8; i++) rom[i] = ent(OP_CMD, 16'h0010 + 16'(i));
      wb = w_data.size();
      pulse_start(0);
      wait_done("t5_done");
      check("t5_nwr", 32'(w_data.size() - wb), 32'd8);
      check("t5_last", 32'(w_data[wb+7]), 32'h0017);
      check("t5_status", 32'({init_done, seq_err, lcd_cs}), 32'b011);
      check("t5_addr", 32'(rom_addr), 32'd7);

      // async reset mid-stream, then replay; start while busy is ignored
      rom[0] = ent(OP_CMD, 16'h0083);
      rom[1] = ent(OP_END, 16'h0000);
      pulse_start(3);
      stream(1, 16'hBB00, 1'b0, sent);
      check("t6a_sent", 32'(sent), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_ctrl", 32'({lcd_cs, lcd_wr, lcd_rd, lcd_rst, lcd_rs,
                               pix_ready, busy, init_done, seq_err}), 32'h1F0);
      check("t6_rst_data", 32'(lcd_data), 32'h0);
      check("t6_rst_addr", 32'(rom_addr), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      wb = w_data.size(); rb = rst_fall.size(); cb = cs_fall.size();
      pulse_start(3);
      repeat (30) @(posedge clk);
      pulse_start(7);
      stream(3, 16'hBB10, 1'b0, sent);
      check("t6_sent", 32'(sent), 32'd3);
      wait_done("t6_done");
      check("t6_rst_edges", 32'(rst_fall.size() - rb), 32'd1);
      check("t6_rst_wait", 32'(cs_fall[cb] - rst_rise[rb]), 32'd30);
      check("t6_first_addr", 32'(cs_addr[cb]), 32'd0);
      check("t6_nwr", 32'(w_data.size() - wb), 32'd4);
      check("t6_cmd", 32'({w_rs[wb], w_data[wb]}), 32'h00083);
      for (int i = 1; i < 4; i++) begin
         check("t6_pix", 32'({w_rs[wb+i], w_data[wb+i]}), 32'h1BB0F + 32'(i));
      end
      check("t6_rate1", 32'(w_fall[wb+2] - w_fall[wb+1]), 32'd5);
      check("t6_rate2", 32'(w_fall[wb+3] - w_fall[wb+2]), 32'd5);
      check("t6_status", 32'({init_done, seq_err, lcd_cs}), 32'b101);
      check("bus_stable", 32'(unstable), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
